// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with a valid/ready
// handshake and a two-entry (head + skid) buffer, so the stage runs at full
// throughput under back-pressure while in_ready stays a pure register decode.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   flush            synchronous kill of all held entries
//   in_valid/ready   upstream handshake; in_data/in_ctrl/in_rd payload
//   out_valid/ready  downstream handshake; out_data/out_ctrl/out_rd head payload
//   occupancy        number of entries held (0..2)
//
// The control field and rd are zero whenever the slot is invalid, so a
// bubble or flushed slot can never write architectural state. Data is
// never cleared (except by reset) to avoid needless toggling.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
  } slot_t;

  state_t state, state_nxt;
  slot_t  head, skid, in_slot;

  logic acc, del;
  logic ld_head_in, ld_head_skid, ld_skid;

  assign in_slot   = '{data: in_data, ctrl: in_ctrl, rd: in_rd};

  // Ready depends only on state: no combinational path from out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;

  assign acc = in_valid & in_ready & ~flush;
  assign del = out_valid & out_ready;

  assign out_data = head.data;
  assign out_ctrl = out_valid ? head.ctrl : '0;
  assign out_rd   = out_valid ? head.rd   : '0;

  always_comb begin
    state_nxt    = state;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: if (acc) begin
        state_nxt  = ONE;
        ld_head_in = 1'b1;
      end
      ONE: begin
        if (acc && del) begin
          ld_head_in = 1'b1;
        end else if (acc) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end else if (del) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (del) begin
        state_nxt    = ONE;
        ld_head_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush overrides everything; a same-cycle delivery already happened.
    if (flush) begin
      state_nxt    = EMPTY;
      ld_head_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      if (ld_head_in)        head <= in_slot;
      else if (ld_head_skid) head <= skid;
      if (ld_skid)           skid <= in_slot;
      if (flush) begin
        // Data registers keep their value; only the state-changing fields die.
        head.ctrl <= '0;
        head.rd   <= '0;
        skid.ctrl <= '0;
        skid.rd   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
module tb_pipe_stage_reg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int RD_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RD_W-1:0]   out_rd;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_rd(out_rd),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = 8'h01; in_rd = 5'd1;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ",       64'(occupancy), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("rst_out_rd",    64'(out_rd),    64'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming 0x1..0xA, one-cycle latency, occupancy 1
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 64'(i);
      step();
      chk("stream_data",  out_data,        64'(i));
      chk("stream_occ",   64'(occupancy),  64'd1);
      chk("stream_ready", 64'(in_ready),   64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);

    // Back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11;
    step();
    chk("bp_occ1", 64'(occupancy), 64'd1);
    in_data = 64'h22;
    step();
    chk("bp_occ2",   64'(occupancy), 64'd2);
    chk("bp_ready0", 64'(in_ready),  64'd0);
    in_data = 64'h33;
    step();
    chk("bp_hold_occ",  64'(occupancy), 64'd2);
    chk("bp_head_11",   out_data,       64'h11);
    out_ready = 1'b1;
    step();
    chk("bp_head_22", out_data,       64'h22);
    chk("bp_occ_1",   64'(occupancy), 64'd1);
    chk("bp_ready1",  64'(in_ready),  64'd1);
    step();
    chk("bp_head_33", out_data,       64'h33);
    chk("bp_occ_1b",  64'(occupancy), 64'd1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 64'(occupancy), 64'd0);

    // Simultaneous accept + deliver in ONE
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h44;
    step();
    chk("sim_head_44", out_data, 64'h44);
    in_data = 64'h55; out_ready = 1'b1;
    step();
    chk("sim_head_55", out_data,       64'h55);
    chk("sim_occ",     64'(occupancy), 64'd1);
    in_valid = 1'b0;
    step();

    // Flush while full with an incoming payload
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h03; in_rd = 5'd2;
    in_data = 64'h66; step();
    in_data = 64'h77; step();
    chk("fl_pre_occ", 64'(occupancy), 64'd2);
    in_data = 64'h88; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_occ",      64'(occupancy), 64'd0);
    chk("fl_valid",    64'(out_valid), 64'd0);
    chk("fl_ctrl",     64'(out_ctrl),  64'd0);
    chk("fl_rd",       64'(out_rd),    64'd0);
    chk("fl_in_ready", 64'(in_ready),  64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_88", 64'(out_valid), 64'd0);

    // Bubble: control/rd visible for exactly one cycle
    in_valid = 1'b1; in_data = 64'h99; in_ctrl = 8'hFF; in_rd = 5'd7;
    step();
    in_valid = 1'b0;
    chk("bub_valid", 64'(out_valid), 64'd1);
    chk("bub_ctrl",  64'(out_ctrl),  64'hFF);
    chk("bub_rd",    64'(out_rd),    64'd7);
    step();
    chk("bub_valid0", 64'(out_valid), 64'd0);
    chk("bub_ctrl0",  64'(out_ctrl),  64'd0);
    chk("bub_rd0",    64'(out_rd),    64'd0);
    chk("bub_data",   out_data,       64'h99);

    // Asynchronous reset while full
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_rd = 5'd9;
    in_data = 64'hA1; step();
    in_data = 64'hA2; step();
    chk("ar_pre_occ", 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_occ",   64'(occupancy), 64'd0);
    chk("ar_ctrl",  64'(out_ctrl),  64'd0);
    chk("ar_data",  out_data,       64'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("ar_stay_empty", 64'(occupancy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
